// File: rtl/cdc_clear_seq_pkg.sv
// cdc_clear_seq shared types.
// Sequencer state encoding.
package cdc_clear_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REQ      = 2'd2,
    WAIT_REL = 2'd3
  } cdc_clr_state_e;

  function automatic int unsigned cw(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_clear_seq_timer.sv
// Drain timeout counter for cdc_clear_seq.
// Built only with CDC_CLEAR_SEQ_TIMEOUT_EN.
module cdc_clear_seq_timer
  import cdc_clear_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int TW = cw(TIMEOUT_CYCLES);

  logic [TW-1:0] cnt_q;

  // restart on drain entry, count while draining
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && !expire) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  assign expire = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cdc_clear_seq.sv
// Clear sequencer upstream of a CDC clear synchronizer.
// Optional drain timeout: CDC_CLEAR_SEQ_TIMEOUT_EN.
module cdc_clear_seq
  import cdc_clear_seq_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_req_i,
  input  logic txn_issue_i,
  input  logic txn_retire_i,
  input  logic sync_clear_i,
  output logic sync_clear_o,
  output logic gate_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o,
  output logic err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]
               outstanding_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  cdc_clr_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic           done_q;
  logic           err_q;
  logic           expire;
  logic           start;
  logic           empty;
  logic           full;
  logic           issue_ok;
  logic           retire_ok;
  logic           issue_err;
  logic           retire_err;

  assign start = (state_q == IDLE) && clear_req_i;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(MAX_OUTSTANDING));

`ifdef CDC_CLEAR_SEQ_TIMEOUT_EN
  logic timeout_q;

  cdc_clear_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load  (start),
    .en    (state_q == DRAIN),
    .expire(expire)
  );

  // sticky abort flag, cleared when a new clear starts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
    end else if (start) begin
      timeout_q <= 1'b0;
    end else if (state_q == DRAIN && !empty && expire) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  // never true for a legal TIMEOUT_CYCLES
  assign expire    = (TIMEOUT_CYCLES < 1);
  assign timeout_o = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (clear_req_i)   state_d = DRAIN;
      DRAIN:    if (empty || expire) state_d = REQ;
      REQ:      if (sync_clear_i)  state_d = WAIT_REL;
      WAIT_REL: if (!sync_clear_i) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // an issue at full is legal when a retire frees a slot
  // in the same cycle, and vice versa at empty
  assign issue_ok  = txn_issue_i && !gate_o &&
                     (!full || txn_retire_i);
  assign retire_ok = txn_retire_i && !sync_clear_i &&
                     (!empty || issue_ok);
  assign issue_err  = txn_issue_i && !issue_ok;
  assign retire_err = txn_retire_i && !sync_clear_i &&
                      !retire_ok;

  // in-flight count, zeroed by any synchronizer clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      unique case (1'b1)
        sync_clear_i:
          cnt_q <= '0;
        issue_ok && !retire_ok:
          cnt_q <= cnt_q + CW'(1);
        retire_ok && !issue_ok:
          cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  // completion pulse and sticky error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state_q == WAIT_REL) && !sync_clear_i;
      err_q  <= err_q | issue_err | retire_err;
    end
  end

  assign sync_clear_o  = (state_q == REQ);
  assign busy_o        = (state_q != IDLE);
  assign gate_o        = busy_o | sync_clear_i;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_cdc_clear_seq.sv
// Self-checking bench for cdc_clear_seq.
// Scoreboard of expected sync_clear_o rise / done_o cycles.
module tb_cdc_clear_seq;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       clear_req_i;
  logic       txn_issue_i;
  logic       txn_retire_i;
  logic       sync_clear_i;
  logic       sync_clear_o;
  logic       gate_o;
  logic       busy_o;
  logic       done_o;
  logic       timeout_o;
  logic       err_o;
  logic [3:0] outstanding_o;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int rise_q[$];
  int done_q[$];
  bit gate_watch = 1'b0;
  bit sc_prev    = 1'b0;

  cdc_clear_seq #(
    .MAX_OUTSTANDING(8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_req_i  (clear_req_i),
    .txn_issue_i  (txn_issue_i),
    .txn_retire_i (txn_retire_i),
    .sync_clear_i (sync_clear_i),
    .sync_clear_o (sync_clear_o),
    .gate_o       (gate_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .err_o        (err_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d",
                  tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int e;
    if (rst_ni) begin
      if (sync_clear_o && !sc_prev) begin
        e = rise_q.size() ? rise_q.pop_front() : -1;
        chk("rise_cyc", cyc, e);
      end
      if (done_o) begin
        e = done_q.size() ? done_q.pop_front() : -1;
        chk("done_cyc", cyc, e);
      end
      if (gate_watch) chk("gate_hold", gate_o, 1);
    end
    sc_prev = sync_clear_o;
  end

  task automatic issue_n(input int k);
    repeat (k) begin
      txn_issue_i = 1'b1;
      tick();
    end
    txn_issue_i = 1'b0;
  endtask

  task automatic serve(input int hold,
                       input int budget);
    int k = 0;
    while (!sync_clear_o && k < budget) begin
      tick();
      k++;
    end
    chk("req_seen", sync_clear_o, 1);
    if (sync_clear_o) begin
      sync_clear_i = 1'b1;
      tick();
      chk("clr_cnt", outstanding_o, 0);
      chk("req_drop", sync_clear_o, 0);
      repeat (hold - 1) tick();
      sync_clear_i = 1'b0;
      gate_watch = 1'b0;
      done_q.push_back(cyc + 1);
      repeat (3) tick();
    end
    gate_watch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: cyc %0d want <20000",
             cyc);
    $fatal(1);
  end

  initial begin
    rst_ni       = 1'b0;
    clear_req_i  = 1'b0;
    txn_issue_i  = 1'b0;
    txn_retire_i = 1'b0;
    sync_clear_i = 1'b0;
    repeat (2) tick();
    chk("rst_sco", sync_clear_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_to", timeout_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", outstanding_o, 0);
    chk("rst_gate", gate_o, 0);
    sync_clear_i = 1'b1;
    #1;
    chk("rst_gate_f", gate_o, 1);
    sync_clear_i = 1'b0;
    #1;
    rst_ni = 1'b1;
    tick();

    // idle clear
    clear_req_i = 1'b1;
    rise_q.push_back(cyc + 2);
    tick();
    clear_req_i = 1'b0;
    chk("idle_busy", busy_o, 1);
    serve(4, 10);
    chk("idle_gate", gate_o, 0);
    chk("idle_busy0", busy_o, 0);

    // far-side clear
    issue_n(5);
    chk("far_cnt5", outstanding_o, 5);
    sync_clear_i = 1'b1;
    #1;
    chk("far_gate1", gate_o, 1);
    tick();
    chk("far_cnt0", outstanding_o, 0);
    chk("far_busy", busy_o, 0);
    chk("far_gate2", gate_o, 1);
    repeat (2) tick();
    sync_clear_i = 1'b0;
    #1;
    chk("far_gate0", gate_o, 0);
    repeat (3) tick();
    chk("far_busy2", busy_o, 0);

    // simultaneous issue and retire
    issue_n(4);
    txn_issue_i  = 1'b1;
    txn_retire_i = 1'b1;
    tick();
    txn_issue_i  = 1'b0;
    txn_retire_i = 1'b0;
    chk("sim_cnt", outstanding_o, 4);
    chk("sim_err", err_o, 0);
    txn_retire_i = 1'b1;
    tick();
    txn_retire_i = 1'b0;
    chk("ret_cnt", outstanding_o, 3);

    // drain with gated issue
    clear_req_i = 1'b1;
    tick();
    clear_req_i = 1'b0;
    gate_watch  = 1'b1;
    txn_issue_i = 1'b1;
    tick();
    txn_issue_i = 1'b0;
    chk("gate_err", err_o, 1);
    chk("gate_cnt", outstanding_o, 3);
    for (int i = 0; i < 3; i++) begin
      repeat (4) tick();
      chk("drn_sco", sync_clear_o, 0);
      txn_retire_i = 1'b1;
      if (i == 2) rise_q.push_back(cyc + 2);
      tick();
      txn_retire_i = 1'b0;
      chk("drn_cnt", outstanding_o, 2 - i);
    end
    serve(4, 10);
    chk("err_sticky", err_o, 1);

    // reset in REQ
    clear_req_i = 1'b1;
    tick();
    clear_req_i = 1'b0;
    tick();
    chk("req_pre", sync_clear_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_sco", sync_clear_o, 0);
    chk("mid_busy", busy_o, 0);
    chk("mid_err", err_o, 0);
    chk("mid_gate", gate_o, 0);
    chk("mid_cnt", outstanding_o, 0);
    chk("mid_to", timeout_o, 0);
    tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    chk("mid_done", done_o, 0);

    // retire at zero
    txn_retire_i = 1'b1;
    tick();
    txn_retire_i = 1'b0;
    chk("ret0_err", err_o, 1);
    chk("ret0_cnt", outstanding_o, 0);

    clear_req_i = 1'b1;
    rise_q.push_back(cyc + 2);
    tick();
    clear_req_i = 1'b0;
    serve(4, 10);
    chk("post_busy", busy_o, 0);

    // stuck drain
    issue_n(2);
    clear_req_i = 1'b1;
`ifdef CDC_CLEAR_SEQ_TIMEOUT_EN
    rise_q.push_back(cyc + 17);
`endif
    tick();
    clear_req_i = 1'b0;
    gate_watch  = 1'b1;
`ifdef CDC_CLEAR_SEQ_TIMEOUT_EN
    serve(4, 30);
    chk("to_flag", timeout_o, 1);
    chk("to_busy", busy_o, 0);
`else
    repeat (40) tick();
    chk("nto_sco", sync_clear_o, 0);
    chk("nto_busy", busy_o, 1);
    chk("nto_cnt", outstanding_o, 2);
    txn_retire_i = 1'b1;
    repeat (2) tick();
    txn_retire_i = 1'b0;
    rise_q.push_back(cyc + 1);
    serve(4, 10);
    chk("nto_flag", timeout_o, 0);
`endif

    repeat (4) tick();
    chk("rise_left", rise_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
